sseg_capture: RTL and testbench
===============================

# sseg_capture

Seven-segment capture block: the receiving end of the segment/anode display interface driven by the team's BCD-to-segment decoders. It samples the multiplexed active-low segment bus and active-low anode lines, debounces each scan slot, and decodes each stable pattern back to a 4-bit hex value per digit. It presents a completed frame of all digits to a checker or host, and flags illegal patterns. It is used for display loopback self-test and for reading another board's display.

## Interface

- `NUM_DIGITS`, default 2: number of multiplexed digits (anode width).
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a slot is committed; legal range 2..255.

- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `sseg_in`  in  7: segments, active-low, bit6=a … bit0=g.
- `an_in`  in  NUM_DIGITS: anodes, active-low; bit i low selects digit i.
- `value_out`  out  4*NUM_DIGITS: decoded nibbles; digit i at [4i+3:4i].
- `digit_valid_out`  out  NUM_DIGITS: bit i set when digit i's last commit matched a legal pattern.
- `frame_valid`  out  1: one-cycle pulse when every digit has been committed since the last frame.
- `err`  out  1: one-cycle pulse on commit of an unknown pattern or of more than one active anode.

## Operation

- Legal patterns, active-low, a..g: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Every edge registers {an_in, sseg_in} into `smp`. `cnt` counts consecutive edges with an unchanged `smp`, including the first. `cnt` saturates at STABLE_CYCLES.
- State machine:
  - SETTLE: counting. When `cnt` reaches STABLE_CYCLES, commit and go to HOLD.
  - HOLD: no further commits. Any change in `smp` sets cnt=1 and returns to SETTLE.
- Commit rules:
  - All anodes high: ignored, no outputs change.
  - Exactly one anode low (digit i), legal pattern: write the nibble to slot i, set `digit_valid_out[i]`, set `seen[i]`.
  - Exactly one anode low, unknown pattern (including blank 1111111): slot i nibble is held, `digit_valid_out[i]` is cleared, `seen[i]` is set, `err` pulses.
  - Two or more anodes low: `err` pulses; no slot, valid bit, or `seen` bit changes.
- When a commit makes `seen` all-ones, `frame_valid` pulses in the same cycle as that commit's output update, and `seen` clears.
- Reset values:
  - Outputs: `value_out`=0, `digit_valid_out`=0, `frame_valid`=0, `err`=0.
  - Internal: `seen`=0, `cnt`=0, state SETTLE, `smp`={all-ones anodes, 1111111}.

## Timing

- Latency: inputs change before edge E0 and are held. `cnt` reaches STABLE_CYCLES at edge E0+STABLE_CYCLES-1. Outputs update at edge E0+STABLE_CYCLES.
- Any input pulse shorter than STABLE_CYCLES edges is never committed.
- At most one commit per stable interval. A slot held indefinitely commits exactly once.
- `rst` asserted mid-count or mid-frame returns every register to its reset value on that edge. No pulse is emitted on that edge.
- Revisiting a digit before the frame completes overwrites its nibble; `seen` is unchanged because the bit is already set.

## Structure

- Package `sseg_pkg` holds:
  - the 16 segment-pattern constants;
  - `SSEG_BLANK`=7'b1111111;
  - the segment bit-order constants.
- Sub-module `sseg_pattern_decode` is combinational. It maps 7-bit pattern to {hit, nibble[3:0]}.
- `sseg_capture` instantiates `sseg_pattern_decode` once and owns `smp`, `cnt`, the FSM, the slot registers, and `seen`.

## Test plan

- Default parameters, with each step held 6 cycles:
  - Step 1: an=10, sseg=0010010.
  - Step 2: an=01, sseg=0001000.
  - Required: `value_out`=8'hA2, `digit_valid_out`=2'b11, one `frame_valid` pulse at edge E0+4 of the second slot.
- Legal slot held 6 cycles, then an=01 with sseg=0000000 for 3 cycles, then back to the previous value: no commit, `value_out` unchanged, no pulses.
- an=10, sseg=1111110 held 5 cycles -> one `err` pulse, `digit_valid_out[0]`=0, nibble 0 retained.
- an=00, sseg=0000110 held 5 cycles -> one `err` pulse, `seen` unchanged, no `frame_valid`.
- Sweep all 16 legal patterns on digit 1 -> nibble 0..F in `value_out[7:4]` each time, `err` never asserted.
- Commit digit 0, assert `rst` for 1 cycle, then commit digit 1 alone -> no `frame_valid` (seen cleared by reset). `value_out[3:0]`=0 after reset.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment capture path: pattern table, blank code, bit order.
// Patterns are active-low, bit6 = segment a down to bit0 = segment g.
package sseg_pkg;

    localparam int unsigned SEG_A = 6;
    localparam int unsigned SEG_B = 5;
    localparam int unsigned SEG_C = 4;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 2;
    localparam int unsigned SEG_F = 1;
    localparam int unsigned SEG_G = 0;

    localparam logic [6:0] SSEG_BLANK = 7'b1111111;

    localparam logic [6:0] SSEG_0 = 7'b0000001;
    localparam logic [6:0] SSEG_1 = 7'b1001111;
    localparam logic [6:0] SSEG_2 = 7'b0010010;
    localparam logic [6:0] SSEG_3 = 7'b0000110;
    localparam logic [6:0] SSEG_4 = 7'b1001100;
    localparam logic [6:0] SSEG_5 = 7'b0100100;
    localparam logic [6:0] SSEG_6 = 7'b0100000;
    localparam logic [6:0] SSEG_7 = 7'b0001111;
    localparam logic [6:0] SSEG_8 = 7'b0000000;
    localparam logic [6:0] SSEG_9 = 7'b0000100;
    localparam logic [6:0] SSEG_A = 7'b0001000;
    localparam logic [6:0] SSEG_B = 7'b1100000;
    localparam logic [6:0] SSEG_C = 7'b0110001;
    localparam logic [6:0] SSEG_D = 7'b1000010;
    localparam logic [6:0] SSEG_E = 7'b0110000;
    localparam logic [6:0] SSEG_F = 7'b0111000;

    // Entry [n] is the pattern for hex digit n.
    localparam logic [15:0][6:0] SSEG_TABLE = {
        SSEG_F, SSEG_E, SSEG_D, SSEG_C, SSEG_B, SSEG_A, SSEG_9, SSEG_8,
        SSEG_7, SSEG_6, SSEG_5, SSEG_4, SSEG_3, SSEG_2, SSEG_1, SSEG_0
    };

    localparam logic [0:0] ST_SETTLE = 1'b0;
    localparam logic [0:0] ST_HOLD   = 1'b1;

    // Reorders a raw bus into table order {a..g}; identity for the standard wiring.
    function automatic logic [6:0] sseg_canon(input logic [6:0] raw);
        return {raw[SEG_A], raw[SEG_B], raw[SEG_C], raw[SEG_D],
                raw[SEG_E], raw[SEG_F], raw[SEG_G]};
    endfunction

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational lookup of a 7-bit active-low segment pattern to {hit, nibble}.
// Zero latency; no flow control. Unknown patterns (blank included) give hit=0, nibble=0.
module sseg_pattern_decode
    import sseg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       hit,
    output logic [3:0] nibble
);

    logic [6:0] canon;

    always_comb begin
        canon  = sseg_canon(pattern);
        hit    = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (canon == SSEG_TABLE[i]) begin
                hit    = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/sseg_capture.sv
// Samples a multiplexed seven-segment display, debounces each scan slot and decodes digits.
// Commit STABLE_CYCLES+1 edges after an input change; no backpressure, pulses are single-cycle.
module sseg_capture
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              sseg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] value_out,
    output logic [NUM_DIGITS-1:0]   digit_valid_out,
    output logic                    frame_valid,
    output logic                    err
);

    localparam int         SW       = NUM_DIGITS + 7;
    localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

    logic [SW-1:0]           smp_q, smp_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [0:0]              state_q, state_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   dv_q, dv_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    frame_q, frame_d;
    logic                    err_q, err_d;

    logic                  dec_hit;
    logic [3:0]            dec_nibble;
    logic [NUM_DIGITS-1:0] sel;
    logic [NUM_DIGITS-1:0] seen_nxt;
    logic                  changed;
    logic                  commit;
    logic                  one_sel;

    sseg_pattern_decode u_decode (
        .pattern (smp_q[6:0]),
        .hit     (dec_hit),
        .nibble  (dec_nibble)
    );

    assign smp_d = {an_in, sseg_in};

    always_comb begin
        cnt_d    = cnt_q;
        state_d  = state_q;
        value_d  = value_q;
        dv_d     = dv_q;
        seen_d   = seen_q;
        frame_d  = 1'b0;
        err_d    = 1'b0;
        seen_nxt = seen_q;

        changed = (smp_d != smp_q);
        commit  = (state_q == ST_SETTLE) && (cnt_q == STABLE_N);
        sel     = ~smp_q[SW-1:7];
        one_sel = (sel != '0) && ((sel & (sel - 1'b1)) == '0);

        if (changed) begin
            cnt_d   = 8'd1;
            state_d = ST_SETTLE;
        end else if (cnt_q != STABLE_N) begin
            cnt_d = cnt_q + 8'd1;
        end

        // A change on the commit edge restarts settling rather than parking in HOLD.
        if (commit) begin
            if (!changed) begin
                state_d = ST_HOLD;
            end
            if (sel != '0 && !one_sel) begin
                err_d = 1'b1;
            end else if (one_sel) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel[i]) begin
                        if (dec_hit) begin
                            value_d[4*i +: 4] = dec_nibble;
                        end
                        dv_d[i] = dec_hit;
                    end
                end
                err_d    = !dec_hit;
                seen_nxt = seen_q | sel;
                if (&seen_nxt) begin
                    frame_d = 1'b1;
                    seen_d  = '0;
                end else begin
                    seen_d = seen_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smp_q   <= '1;
            cnt_q   <= 8'd0;
            state_q <= ST_SETTLE;
            value_q <= '0;
            dv_q    <= '0;
            seen_q  <= '0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            smp_q   <= smp_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            value_q <= value_d;
            dv_q    <= dv_d;
            seen_q  <= seen_d;
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

    assign value_out       = value_q;
    assign digit_valid_out = dv_q;
    assign frame_valid     = frame_q;
    assign err             = err_q;

endmodule

// File: tb/tb_sseg_capture.sv
// Bench for sseg_capture: directed vector table, a few hand sequences, then random stimulus
// checked cycle by cycle against a run-length reference model.
module tb_sseg_capture;

    localparam int ND = 2;
    localparam int S  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    sseg_in;
    logic [ND-1:0] an_in;
    logic [4*ND-1:0] value_out;
    logic [ND-1:0] digit_valid_out;
    logic          frame_valid;
    logic          err;

    always #5 clk = ~clk;

    sseg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
        .clk             (clk),
        .rst             (rst),
        .sseg_in         (sseg_in),
        .an_in           (an_in),
        .value_out       (value_out),
        .digit_valid_out (digit_valid_out),
        .frame_valid     (frame_valid),
        .err             (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    logic [6:0] pats [16];

    // Reference model: a commit happens on the edge after the sample has been seen S times in a row.
    int            run_len;
    logic [8:0]    cur;
    logic [7:0]    m_val;
    logic [1:0]    m_dv;
    logic [1:0]    m_seen;
    bit            m_frm;
    bit            m_err;

    task automatic model_step();
        int   lows;
        int   d;
        int   n;
        if (rst) begin
            run_len = 0; cur = '1; m_val = '0; m_dv = '0; m_seen = '0; m_frm = 0; m_err = 0;
        end else begin
            m_frm = 0; m_err = 0;
            if (run_len == S) begin
                lows = 0; d = 0;
                for (int i = 0; i < ND; i++) if (cur[7+i] == 1'b0) begin lows++; d = i; end
                if (lows >= 2) m_err = 1;
                else if (lows == 1) begin
                    n = -1;
                    for (int p = 0; p < 16; p++) if (pats[p] == cur[6:0]) n = p;
                    if (n >= 0) begin
                        m_val[d*4 +: 4] = 4'(n);
                        m_dv[d] = 1'b1;
                    end else begin
                        m_dv[d] = 1'b0;
                        m_err = 1;
                    end
                    m_seen[d] = 1'b1;
                    if (m_seen == 2'b11) begin m_frm = 1; m_seen = '0; end
                end
            end
            if ({an_in, sseg_in} == cur) run_len++;
            else begin cur = {an_in, sseg_in}; run_len = 1; end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_value", longint'(value_out), longint'(m_val));
        check("model_dv", longint'(digit_valid_out), longint'(m_dv));
        check("model_frame", longint'(frame_valid), longint'(m_frm));
        check("model_err", longint'(err), longint'(m_err));
    endtask

    typedef struct {
        bit         rst;
        logic [1:0] an;
        logic [6:0] seg;
        int         cyc;
        logic [7:0] exp_val;
        logic [1:0] exp_dv;
        int         frm_at;
        int         err_at;
    } vec_t;

    vec_t vt [29];

    initial begin
        int frm_first, frm_n, err_first, err_n;
        int n_rand_err;
        logic [7:0] v8;

        pats = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

        run_len = 0; cur = '1; m_val = '0; m_dv = '0; m_seen = '0; m_frm = 0; m_err = 0;
        rst = 1'b1; an_in = '1; sseg_in = '1;

        vt[0]  = '{1, 2'b11, 7'h7f,       1, 8'h00, 2'b00, -1, -1};
        vt[1]  = '{0, 2'b10, 7'b0010010,  6, 8'h02, 2'b01, -1, -1};
        vt[2]  = '{0, 2'b01, 7'b0001000,  6, 8'hA2, 2'b11,  4, -1};
        vt[3]  = '{0, 2'b01, 7'b0000000,  3, 8'hA2, 2'b11, -1, -1};
        vt[4]  = '{0, 2'b01, 7'b0001000,  6, 8'hA2, 2'b11, -1, -1};
        vt[5]  = '{1, 2'b11, 7'h7f,       1, 8'h00, 2'b00, -1, -1};
        vt[6]  = '{0, 2'b10, 7'b1111110,  5, 8'h00, 2'b00, -1,  4};
        vt[7]  = '{0, 2'b00, 7'b0000110,  5, 8'h00, 2'b00, -1,  4};
        vt[8]  = '{0, 2'b01, 7'b0000110,  5, 8'h30, 2'b10,  4, -1};
        vt[9]  = '{1, 2'b11, 7'h7f,       1, 8'h00, 2'b00, -1, -1};
        vt[10] = '{0, 2'b10, 7'b0100100,  5, 8'h05, 2'b01, -1, -1};
        vt[11] = '{1, 2'b11, 7'h7f,       1, 8'h00, 2'b00, -1, -1};
        vt[12] = '{0, 2'b01, 7'b0001111,  5, 8'h70, 2'b10, -1, -1};
        for (int i = 0; i < 16; i++) begin
            v8 = 8'(i << 4);
            vt[13+i] = '{0, 2'b01, pats[i], 5, v8, 2'b10, -1, -1};
        end

        @(negedge clk);
        for (int v = 0; v < 29; v++) begin
            rst = vt[v].rst; an_in = vt[v].an; sseg_in = vt[v].seg;
            frm_first = -1; frm_n = 0; err_first = -1; err_n = 0;
            for (int k = 0; k < vt[v].cyc; k++) begin
                tick();
                if (frame_valid) begin if (frm_first < 0) frm_first = k; frm_n++; end
                if (err) begin if (err_first < 0) err_first = k; err_n++; end
            end
            check($sformatf("vec%0d_value", v), longint'(value_out), longint'(vt[v].exp_val));
            check($sformatf("vec%0d_dv", v), longint'(digit_valid_out), longint'(vt[v].exp_dv));
            check($sformatf("vec%0d_frame_edge", v), frm_first, vt[v].frm_at);
            check($sformatf("vec%0d_frame_count", v), frm_n, (vt[v].frm_at >= 0) ? 1 : 0);
            check($sformatf("vec%0d_err_edge", v), err_first, vt[v].err_at);
            check($sformatf("vec%0d_err_count", v), err_n, (vt[v].err_at >= 0) ? 1 : 0);
        end

        // Exact commit latency: nothing at E0+3, nibble at E0+4.
        rst = 1'b1; an_in = '1; sseg_in = '1; tick();
        rst = 1'b0; an_in = 2'b10; sseg_in = 7'b0000100;
        for (int k = 0; k < 4; k++) tick();
        check("latency_early", longint'(value_out[3:0]), 0);
        tick();
        check("latency_commit", longint'(value_out[3:0]), 9);

        // Reset landing on the commit edge suppresses the commit and its pulses.
        rst = 1'b1; an_in = '1; sseg_in = '1; tick();
        rst = 1'b0; an_in = 2'b10; sseg_in = 7'b1111111;
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1; tick();
        check("rst_commit_err", longint'(err), 0);
        check("rst_commit_frame", longint'(frame_valid), 0);
        check("rst_commit_dv", longint'(digit_valid_out), 0);
        rst = 1'b0;

        // A slot held indefinitely commits once.
        an_in = 2'b01; sseg_in = 7'b1111110; err_n = 0;
        for (int k = 0; k < 40; k++) begin tick(); if (err) err_n++; end
        check("long_hold_err_count", err_n, 1);

        // Random stimulus against the model.
        n_rand_err = 0;
        for (int s = 0; s < 300; s++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            rst = ($urandom_range(0, 39) == 0);
            if (kind == 0) an_in = 2'b11;
            else if (kind == 1) an_in = 2'b00;
            else an_in = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
            if ($urandom_range(0, 3) == 0) sseg_in = 7'($urandom);
            else sseg_in = pats[$urandom_range(0, 15)];
            for (int k = 0; k < int'($urandom_range(1, 7)); k++) begin
                tick();
                if (err) n_rand_err++;
            end
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
